// File: rtl/seq_det.sv
// Serial 8-bit pattern detector with fill tracking and saturating match counter.
// Define SEQ_DET_OVERLAP_EN for overlapping detection; the default build is non-overlapping.
module seq_det #(
   parameter logic [7:0] PATTERN = 8'hB6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       din_valid,
   input  logic       din,
   input  logic       clear,
   output logic       detected,
   output logic [7:0] match_count,
   output logic [3:0] fill
);

   localparam int unsigned HIST_W  = 8;
   localparam int unsigned FILL_W  = 4;
   localparam int unsigned COUNT_W = 8;

   localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(HIST_W);
   localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

   logic [HIST_W-1:0]  shreg_q, shreg_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [FILL_W-1:0]  fill_inc;
   logic [COUNT_W-1:0] match_count_q, match_count_d;
   logic               detected_q, detected_d;

   // State register; reset dominates clear and din_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q       <= '0;
         fill_q        <= '0;
         match_count_q <= '0;
         detected_q    <= 1'b0;
      end else begin
         shreg_q       <= shreg_d;
         fill_q        <= fill_d;
         match_count_q <= match_count_d;
         detected_q    <= detected_d;
      end
   end

   // History shift, fill tracking and match evaluation on next-state values
   always_comb begin
      shreg_d       = shreg_q;
      fill_d        = fill_q;
      match_count_d = match_count_q;
      detected_d    = 1'b0;
      fill_inc      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

      if (clear) begin
         shreg_d = '0;
         fill_d  = '0;
      end else if (din_valid) begin
         shreg_d = {shreg_q[HIST_W-2:0], din};
         fill_d  = fill_inc;
         if ((fill_inc == FILL_FULL) && ({shreg_q[HIST_W-2:0], din} == PATTERN)) begin
            detected_d = 1'b1;
            if (match_count_q != COUNT_MAX) begin
               match_count_d = match_count_q + COUNT_W'(1);
            end
`ifdef SEQ_DET_OVERLAP_EN
            fill_d = FILL_FULL;
`else
            fill_d = '0;
`endif
         end
      end
   end

   assign detected    = detected_q;
   assign match_count = match_count_q;
   assign fill        = fill_q;

endmodule

// File: tb/tb_seq_det.sv
// Directed self-checking bench for seq_det; expectations adapt to SEQ_DET_OVERLAP_EN.
module tb_seq_det;

`ifdef SEQ_DET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       din_valid;
   logic       din;
   logic       clear;
   logic       detected;
   logic [7:0] match_count;
   logic [3:0] fill;

   int n_cmp;
   int n_err;
   int pulses;
   int p0;

   seq_det #(.PATTERN(8'hB6)) dut (
      .clk         (clk),
      .reset       (reset),
      .din_valid   (din_valid),
      .din         (din),
      .clear       (clear),
      .detected    (detected),
      .match_count (match_count),
      .fill        (fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // detected is a one-cycle pulse, so each pulse is seen exactly once here
   always @(negedge clk) begin
      if (detected === 1'b1) pulses = pulses + 1;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock with the given inputs; outputs are stable 1 time unit after the edge
   task automatic drive(input logic v, input logic b, input logic clr, input logic rst);
      din_valid = v;
      din       = b;
      clear     = clr;
      reset     = rst;
      @(posedge clk);
      #1;
      din_valid = 1'b0;
      din       = 1'b0;
      clear     = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic feed_bits(input logic [7:0] p, input int first, input int last);
      for (int i = first; i >= last; i--) drive(1'b1, p[i], 1'b0, 1'b0);
   endtask

   initial begin
      logic [10:0] stream;
      n_cmp  = 0;
      n_err  = 0;
      pulses = 0;
      din_valid = 1'b0;
      din       = 1'b0;
      clear     = 1'b0;
      reset     = 1'b0;

      // Reset state, held for two cycles
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      check("rst_det", int'(detected), 0);
      check("rst_cnt", int'(match_count), 0);
      check("rst_fill", int'(fill), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_hold_fill", int'(fill), 0);

      // Single pattern
      p0 = pulses;
      feed_bits(8'hB6, 7, 1);
      check("pat_fill7", int'(fill), 7);
      check("pat_nodet7", int'(detected), 0);
      feed_bits(8'hB6, 0, 0);
      check("pat_det", int'(detected), 1);
      check("pat_cnt", int'(match_count), 1);
      check("pat_fill", int'(fill), OVL ? 8 : 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("pat_det_off", int'(detected), 0);
      check("pat_pulses", pulses - p0, 1);

      // 11-bit stream 10110110110
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      p0 = pulses;
      stream = 11'b101_1011_0110;
      for (int i = 10; i >= 0; i--) drive(1'b1, stream[i], 1'b0, 1'b0);
      check("str_det_last", int'(detected), OVL ? 1 : 0);
      check("str_cnt", int'(match_count), OVL ? 2 : 1);
      check("str_fill", int'(fill), OVL ? 8 : 3);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("str_pulses", pulses - p0, OVL ? 2 : 1);

      // Near miss 8'hB7 must not detect
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      p0 = pulses;
      feed_bits(8'hB7, 7, 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("miss_pulses", pulses - p0, 0);
      check("miss_fill", int'(fill), 8);

      // Gap of 3 invalid cycles between bits 4 and 5
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      p0 = pulses;
      feed_bits(8'hB6, 7, 4);
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0);
         check("gap_fill", int'(fill), 4);
      end
      feed_bits(8'hB6, 3, 0);
      check("gap_det", int'(detected), 1);
      check("gap_cnt", int'(match_count), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("gap_pulses", pulses - p0, 1);

      // Clear wins over a valid bit; match_count held at 1
      p0 = pulses;
      feed_bits(8'hB6, 7, 3);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      check("clr_fill", int'(fill), 0);
      check("clr_cnt", int'(match_count), 1);
      feed_bits(8'hB6, 2, 0);
      check("clr_fill3", int'(fill), 3);
      check("clr_cnt_held", int'(match_count), 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("clr_pulses", pulses - p0, 0);

      // Reset mid-pattern beats clear and din_valid
      p0 = pulses;
      feed_bits(8'hB6, 7, 2);
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check("mid_rst_fill", int'(fill), 0);
      check("mid_rst_cnt", int'(match_count), 0);
      feed_bits(8'hB6, 1, 0);
      check("mid_rst_fill2", int'(fill), 2);
      check("mid_rst_cnt0", int'(match_count), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("mid_rst_pulses", pulses - p0, 0);

      // 300 back-to-back patterns: counter saturates, pulses continue
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      p0 = pulses;
      for (int m = 1; m <= 300; m++) begin
         feed_bits(8'hB6, 7, 0);
         if (m == 254) check("sat_cnt254", int'(match_count), 254);
         if (m == 255) check("sat_cnt255", int'(match_count), 255);
         if (m == 256) check("sat_cnt256", int'(match_count), 255);
      end
      check("sat_det_last", int'(detected), 1);
      check("sat_cnt", int'(match_count), 255);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("sat_pulses", pulses - p0, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
